// File: rtl/fetch_skid_queue.sv
// ---------------------------------------------------------------------------
// fetch_skid_queue
//
// IF/ID boundary buffer. It sits between instruction memory and decode and
// holds up to DEPTH {pc, instruction} pairs.
//
// - While decode is stalled, every fetch still in flight is queued.
// - When the stall releases, the queue drains in order, one word per cycle.
// - A branch flush empties the queue. It then drops the next FLUSH_BUBBLES
//   cycles of input, because those are wrong-path fetches.
// - fetch_hold tells the PC to stop before the queue can overflow.
//
// Handshake: the fetch side has no ready signal. A word is offered whenever
// in_valid is high, and it is either taken or dropped in that same cycle.
// Back-pressure comes only from fetch_hold. fetch_hold asserts FETCH_LAT
// entries early, so that fetches already issued still find room in the
// queue.
//
// Ports
//   clk             clock, all state changes on the rising edge
//   rst             synchronous active-high reset
//   in_valid        fetched word present this cycle
//   in_pc           pc of the fetched word
//   in_instr        fetched instruction
//   stall           decode hold
//   if_flush        branch taken in EX; clears the queue, starts discard
//   pc_id           decode pc
//   instruction_id  decode instruction
//   valid_id        decode word is real (0 = bubble)
//   count           queue occupancy
//   fetch_hold      PC must not advance (count >= DEPTH-FETCH_LAT)
//   overflow        sticky: a word arrived while stalled with a full queue
// ---------------------------------------------------------------------------
module fetch_skid_queue #(
    parameter int              XLEN          = 32,
    parameter int              DEPTH         = 4,
    parameter int              FETCH_LAT     = 2,
    parameter int              FLUSH_BUBBLES = 2,
    parameter logic [XLEN-1:0] NOP           = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [XLEN-1:0]          in_pc,
    input  logic [XLEN-1:0]          in_instr,
    input  logic                     stall,
    input  logic                     if_flush,
    output logic [XLEN-1:0]          pc_id,
    output logic [XLEN-1:0]          instruction_id,
    output logic                     valid_id,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     fetch_hold,
    output logic                     overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int DW = (FLUSH_BUBBLES > 0) ? $clog2(FLUSH_BUBBLES + 1) : 1;

    localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
    localparam logic [CW-1:0] HOLD_TH   = CW'(DEPTH - FETCH_LAT);
    localparam logic [DW-1:0] DISC_LOAD = DW'(FLUSH_BUBBLES);

    logic [XLEN-1:0] fifo_pc    [DEPTH];
    logic [XLEN-1:0] fifo_instr [DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [DW-1:0]   disc;

    logic accept;
    logic fifo_empty;
    logic fifo_full;
    logic push;
    logic pop;

    // Pointers wrap freely because DEPTH is a power of two. The occupancy
    // counter is what tells full from empty.
    always_comb begin
        accept     = in_valid && (disc == '0);
        fifo_empty = (count == '0);
        fifo_full  = (count == FULL_CNT);
        push       = 1'b0;
        pop        = 1'b0;
        if (!rst && !if_flush) begin
            if (stall) begin
                push = accept && !fifo_full;
            end else begin
                pop  = !fifo_empty;
                // When the queue is empty, an accepted word bypasses it
                // straight into the ID register. It is only pushed here
                // when a pop frees a slot in the same cycle.
                push = accept && !fifo_empty;
            end
        end
    end

    assign fetch_hold = (count >= HOLD_TH);

    // The storage array has no reset. The pointers and count decide which
    // entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc[wr_ptr]    <= in_pc;
            fifo_instr[wr_ptr] <= in_instr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_id          <= '0;
            instruction_id <= NOP;
            valid_id       <= 1'b0;
            rd_ptr         <= '0;
            wr_ptr         <= '0;
            count          <= '0;
            disc           <= '0;
            overflow       <= 1'b0;
        end else if (if_flush) begin
            // A flush takes priority over stall. The decode slot shows a
            // bubble that carries the redirect pc.
            pc_id          <= in_pc;
            instruction_id <= NOP;
            valid_id       <= 1'b0;
            rd_ptr         <= '0;
            wr_ptr         <= '0;
            count          <= '0;
            disc           <= DISC_LOAD;
        end else begin
            if (disc != '0) begin
                disc <= disc - DW'(1);
            end
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end

            if (stall) begin
                if (accept && fifo_full) begin
                    overflow <= 1'b1;
                end
            end else if (!fifo_empty) begin
                pc_id          <= fifo_pc[rd_ptr];
                instruction_id <= fifo_instr[rd_ptr];
                valid_id       <= 1'b1;
            end else if (accept) begin
                pc_id          <= in_pc;
                instruction_id <= in_instr;
                valid_id       <= 1'b1;
            end else begin
                pc_id          <= in_pc;
                instruction_id <= NOP;
                valid_id       <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fetch_skid_queue.sv
// ---------------------------------------------------------------------------
// tb_fetch_skid_queue
//
// Directed bench for fetch_skid_queue with default parameters.
//
// A queue-based reference model advances on every rising edge. A negedge
// process compares every DUT output against that model. The directed
// sequence also pins the expected values by hand at key points.
// ---------------------------------------------------------------------------
module tb_fetch_skid_queue;

    localparam int          XLEN  = 32;
    localparam int          DEPTH = 4;
    localparam int          FLAT  = 2;
    localparam int          FB    = 2;
    localparam logic [31:0] NOP   = 32'h0;

    // ------------------------------------------------------------ clock/reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic            in_valid = 1'b0;
    logic [XLEN-1:0] in_pc    = '0;
    logic [XLEN-1:0] in_instr = '0;
    logic            stall    = 1'b0;
    logic            if_flush = 1'b0;

    logic [XLEN-1:0] pc_id;
    logic [XLEN-1:0] instruction_id;
    logic            valid_id;
    logic [2:0]      count;
    logic            fetch_hold;
    logic            overflow;

    fetch_skid_queue #(
        .XLEN(XLEN), .DEPTH(DEPTH), .FETCH_LAT(FLAT), .FLUSH_BUBBLES(FB), .NOP(NOP)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_pc(in_pc), .in_instr(in_instr),
        .stall(stall), .if_flush(if_flush),
        .pc_id(pc_id), .instruction_id(instruction_id), .valid_id(valid_id),
        .count(count), .fetch_hold(fetch_hold), .overflow(overflow)
    );

    // ------------------------------------------------------------ scoreboard
    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mk(input logic [31:0] pc);
        return 32'h1300_0000 | pc;
    endfunction

    // ------------------------------------------------------------ model
    // The queue holds {pc, instr} pairs in arrival order.
    logic [63:0] exp_q[$];
    logic [63:0] m_head;
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic        m_valid;
    logic        m_ovf;
    int          m_disc;
    bit          m_acc;
    bit          model_ready = 0;

    always @(posedge clk) begin
        m_acc = in_valid && (m_disc == 0);
        if (rst) begin
            exp_q.delete();
            m_pc = 0; m_instr = NOP; m_valid = 0; m_disc = 0; m_ovf = 0;
            model_ready = 1;
        end else if (if_flush) begin
            exp_q.delete();
            m_pc = in_pc; m_instr = NOP; m_valid = 0; m_disc = FB;
        end else begin
            if (stall) begin
                if (m_acc) begin
                    if (exp_q.size() == DEPTH) m_ovf = 1;
                    else exp_q.push_back({in_pc, in_instr});
                end
            end else if (exp_q.size() > 0) begin
                m_head = exp_q.pop_front();
                m_pc = m_head[63:32]; m_instr = m_head[31:0]; m_valid = 1;
                if (m_acc) exp_q.push_back({in_pc, in_instr});
            end else if (m_acc) begin
                m_pc = in_pc; m_instr = in_instr; m_valid = 1;
            end else begin
                m_pc = in_pc; m_instr = NOP; m_valid = 0;
            end
            if (m_disc > 0) m_disc--;
        end
    end

    always @(negedge clk) begin
        if (model_ready) begin
            chk("m_pc_id", {32'h0, pc_id}, {32'h0, m_pc});
            chk("m_instr", {32'h0, instruction_id}, {32'h0, m_instr});
            chk("m_valid", {63'h0, valid_id}, {63'h0, m_valid});
            chk("m_count", {61'h0, count}, 64'(exp_q.size()));
            chk("m_hold", {63'h0, fetch_hold}, {63'h0, (exp_q.size() >= DEPTH - FLAT)});
            chk("m_ovf", {63'h0, overflow}, {63'h0, m_ovf});
        end
    end

    // ------------------------------------------------------------ driver
    task automatic cycle(input logic v, input logic [31:0] pc, input logic st, input logic fl);
        in_valid = v;
        in_pc    = pc;
        in_instr = mk(pc);
        stall    = st;
        if_flush = fl;
        @(posedge clk);
        #2;
    endtask

    task automatic lit(input string name, input logic [31:0] pc_e, input logic v_e, input int cnt_e);
        chk({name, "_pc"}, {32'h0, pc_id}, {32'h0, pc_e});
        chk({name, "_valid"}, {63'h0, valid_id}, {63'h0, v_e});
        chk({name, "_count"}, {61'h0, count}, 64'(cnt_e));
    endtask

    // ------------------------------------------------------------ sequence
    initial begin
        // reset
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 0);
        lit("reset", 32'h0, 0, 0);
        chk("reset_instr", {32'h0, instruction_id}, {32'h0, NOP});
        chk("reset_hold", {63'h0, fetch_hold}, 64'h0);
        chk("reset_ovf", {63'h0, overflow}, 64'h0);
        rst = 1'b0;

        // streaming bypass
        for (int i = 0; i < 8; i++) begin
            cycle(1, 32'(i * 4), 0, 0);
            lit("stream", 32'(i * 4), 1, 0);
        end
        chk("stream_instr", {32'h0, instruction_id}, {32'h0, 32'h1300_001C});

        // stall for 3 words, then release
        cycle(1, 32'h20, 1, 0); lit("stall1", 32'h1C, 1, 1);
        cycle(1, 32'h24, 1, 0); lit("stall2", 32'h1C, 1, 2);
        cycle(1, 32'h28, 1, 0); lit("stall3", 32'h1C, 1, 3);
        cycle(0, 32'h0, 0, 0);  lit("drain1", 32'h20, 1, 2);
        cycle(0, 32'h0, 0, 0);  lit("drain2", 32'h24, 1, 1);
        cycle(0, 32'h0, 0, 0);  lit("drain3", 32'h28, 1, 0);
        chk("drain3_instr", {32'h0, instruction_id}, {32'h0, 32'h1300_0028});
        cycle(1, 32'h2C, 0, 0); lit("rebypass", 32'h2C, 1, 0);

        // flush with 2 queued
        cycle(1, 32'h40, 1, 0);
        cycle(1, 32'h44, 1, 0); lit("preflush", 32'h2C, 1, 2);
        cycle(1, 32'h60, 0, 1); lit("flush", 32'h60, 0, 0);
        chk("flush_instr", {32'h0, instruction_id}, {32'h0, NOP});
        cycle(1, 32'h30, 0, 0); lit("drop30", 32'h30, 0, 0);
        cycle(1, 32'h34, 0, 0); lit("drop34", 32'h34, 0, 0);
        cycle(1, 32'h80, 0, 0); lit("take80", 32'h80, 1, 0);

        // back-to-back flushes one cycle apart
        cycle(1, 32'h90, 0, 1); lit("bb_f1", 32'h90, 0, 0);
        cycle(1, 32'h94, 0, 0); lit("bb_d0", 32'h94, 0, 0);
        cycle(1, 32'h98, 0, 1); lit("bb_f2", 32'h98, 0, 0);
        cycle(1, 32'h9C, 0, 0); lit("bb_d1", 32'h9C, 0, 0);
        cycle(1, 32'hA0, 0, 0); lit("bb_d2", 32'hA0, 0, 0);
        cycle(1, 32'hA4, 0, 0); lit("bb_take", 32'hA4, 1, 0);

        // flush together with stall, 1 word queued
        cycle(1, 32'hB0, 1, 0); lit("fs_q", 32'hA4, 1, 1);
        cycle(1, 32'hB4, 1, 1); lit("fs", 32'hB4, 0, 0);
        chk("fs_instr", {32'h0, instruction_id}, {32'h0, NOP});
        cycle(0, 32'h0, 0, 0);
        cycle(0, 32'h0, 0, 0);

        // fill to overflow
        cycle(1, 32'hC0, 1, 0); chk("fill1_hold", {63'h0, fetch_hold}, 64'h0);
        cycle(1, 32'hC4, 1, 0); chk("fill2_hold", {63'h0, fetch_hold}, 64'h1);
        lit("fill2", 32'h0, 0, 2);
        cycle(1, 32'hC8, 1, 0);
        cycle(1, 32'hCC, 1, 0); chk("fill4_ovf", {63'h0, overflow}, 64'h0);
        cycle(1, 32'hD0, 1, 0); chk("fill5_ovf", {63'h0, overflow}, 64'h1);
        lit("fill5", 32'h0, 0, 4);
        cycle(0, 32'h0, 0, 0); lit("of_d1", 32'hC0, 1, 3);
        cycle(0, 32'h0, 0, 0); lit("of_d2", 32'hC4, 1, 2);
        cycle(0, 32'h0, 0, 0); lit("of_d3", 32'hC8, 1, 1);
        cycle(0, 32'h0, 0, 0); lit("of_d4", 32'hCC, 1, 0);
        cycle(0, 32'h0, 0, 0); lit("of_idle", 32'h0, 0, 0);
        chk("ovf_sticky", {63'h0, overflow}, 64'h1);

        // reset mid-drain
        cycle(1, 32'hE0, 1, 0);
        cycle(1, 32'hE4, 1, 0);
        cycle(0, 32'h0, 0, 0); lit("md_d1", 32'hE0, 1, 1);
        rst = 1'b1;
        cycle(0, 32'h0, 0, 0); lit("md_rst", 32'h0, 0, 0);
        chk("md_rst_ovf", {63'h0, overflow}, 64'h0);
        rst = 1'b0;
        cycle(1, 32'hF0, 0, 0); lit("post_rst", 32'hF0, 1, 0);
        cycle(0, 32'h0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
